// File: rtl/vga_timing_pkg.sv
// Shared timing constants, framebuffer geometry and scan flag payload for the VGA scan-out path.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_X_W    = 9;
  localparam int unsigned FB_Y_W    = 8;
  localparam int unsigned CNT_W     = 10;

  localparam int unsigned PIX_W = 3;
  localparam int unsigned PIX_R = 2;
  localparam int unsigned PIX_G = 1;
  localparam int unsigned PIX_B = 0;
  localparam int unsigned COL_W = 4;

  typedef struct packed {
    logic visible;
    logic vblank;
    logic hsync_n;
    logic vsync_n;
    logic origin;
  } scan_flags_t;

  localparam scan_flags_t FLAGS_RST = '{visible: 1'b0, vblank: 1'b1, hsync_n: 1'b1,
                                        vsync_n: 1'b1, origin: 1'b0};

  // y*FB_WIDTH + x with FB_WIDTH = 320 = 256 + 64
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_Y_W-1:0] y,
                                                   input logic [FB_X_W-1:0] x);
    return (FB_ADDR_W'(y) << 8) + (FB_ADDR_W'(y) << 6) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port: registered address out, 1-CLK synchronous read data back.
interface vga_scanout_if;
  import vga_timing_pkg::*;

  logic [FB_ADDR_W-1:0] O_VRAM_ADDR;
  logic [PIX_W-1:0]     I_VRAM_DATA;

  modport master (output O_VRAM_ADDR, input I_VRAM_DATA);
  modport slave  (input O_VRAM_ADDR, output I_VRAM_DATA);
endinterface

// File: rtl/vga_sync_gen.sv
// Stage 0: pixel divider, h/v position counters and the timing flags decoded from them.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              tick_c_o,
  output logic [FB_X_W-1:0] fb_x_c_o,
  output logic [FB_Y_W-1:0] fb_y_c_o,
  output scan_flags_t       flags_c_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             tick;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Both counters wrap on the same tick at the last pixel of the last line.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      div_d = '0;
      if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + CNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign tick_c_o  = tick;
  assign fb_x_c_o  = hcnt_q[CNT_W-1:1];
  assign fb_y_c_o  = vcnt_q[FB_Y_W:1];
  assign flags_c_o = '{
    visible: (hcnt_q < CNT_W'(H_VISIBLE)) && (vcnt_q < CNT_W'(V_VISIBLE)),
    vblank:  (vcnt_q >= CNT_W'(V_VISIBLE)),
    hsync_n: !((hcnt_q >= CNT_W'(H_VISIBLE + H_FP)) &&
               (hcnt_q <  CNT_W'(H_VISIBLE + H_FP + H_SYNC))),
    vsync_n: !((vcnt_q >= CNT_W'(V_VISIBLE + V_FP)) &&
               (vcnt_q <  CNT_W'(V_VISIBLE + V_FP + V_SYNC))),
    origin:  (hcnt_q == '0) && (vcnt_q == '0)
  };

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: stage-1 framebuffer address, stage-2 pin registers for sync, colour and status.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic                 CLK,
  input  logic                 I_RESET,
  vga_scanout_if.master        vram,
  output logic                 O_HSYNC,
  output logic                 O_VSYNC,
  output logic [COL_W-1:0]     O_VIDEO_R,
  output logic [COL_W-1:0]     O_VIDEO_G,
  output logic [COL_W-1:0]     O_VIDEO_B,
  output logic                 O_VBLANK,
  output logic                 O_FRAME_START
);

  logic              tick;
  logic [FB_X_W-1:0] fb_x;
  logic [FB_Y_W-1:0] fb_y;
  scan_flags_t       s0_flags;

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV),
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk_i     (CLK),
    .rst_i     (I_RESET),
    .tick_c_o  (tick),
    .fb_x_c_o  (fb_x),
    .fb_y_c_o  (fb_y),
    .flags_c_o (s0_flags)
  );

  scan_flags_t          s1_q, s1_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 vblank_q, vblank_d, fstart_q, fstart_d;

  // Stage 2 samples read data the address has held for CLK_DIV cycles, so sync and colour leave together.
  always_comb begin
    s1_d     = s1_q;
    addr_d   = addr_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vblank_d = vblank_q;
    fstart_d = 1'b0;
    if (tick) begin
      s1_d     = s0_flags;
      addr_d   = s0_flags.visible ? fb_addr(fb_y, fb_x) : '0;
      r_d      = s1_q.visible ? {COL_W{vram.I_VRAM_DATA[PIX_R]}} : '0;
      g_d      = s1_q.visible ? {COL_W{vram.I_VRAM_DATA[PIX_G]}} : '0;
      b_d      = s1_q.visible ? {COL_W{vram.I_VRAM_DATA[PIX_B]}} : '0;
      hsync_d  = s1_q.hsync_n;
      vsync_d  = s1_q.vsync_n;
      vblank_d = s1_q.vblank;
      fstart_d = s1_q.origin;
    end
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      s1_q     <= FLAGS_RST;
      addr_q   <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      addr_q   <= addr_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
      fstart_q <= fstart_d;
    end
  end

  assign vram.O_VRAM_ADDR = addr_q;
  assign O_HSYNC          = hsync_q;
  assign O_VSYNC          = vsync_q;
  assign O_VIDEO_R        = r_q;
  assign O_VIDEO_G        = g_q;
  assign O_VIDEO_B        = b_q;
  assign O_VBLANK         = vblank_q;
  assign O_FRAME_START    = fstart_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: full horizontal timing, a 15-line frame to keep runs short.
module tb_vga_scanout;

  localparam int K_ADDR = 0, K_RGB = 1, K_HS = 2, K_VS = 3, K_VB = 4, K_FS = 5;
  localparam int K_HSLOW = 6, K_VSLOW = 7, K_FSCNT = 8;

  typedef struct {
    int unsigned at;
    int          kind;
    int unsigned val;
  } exp_t;

  logic       CLK = 1'b0;
  logic       I_RESET = 1'b1;
  logic       O_HSYNC, O_VSYNC, O_VBLANK, O_FRAME_START;
  logic [3:0] O_VIDEO_R, O_VIDEO_G, O_VIDEO_B;

  vga_scanout_if vram ();

  vga_scanout #(
    .CLK_DIV(2),
    .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .CLK           (CLK),
    .I_RESET       (I_RESET),
    .vram          (vram),
    .O_HSYNC       (O_HSYNC),
    .O_VSYNC       (O_VSYNC),
    .O_VIDEO_R     (O_VIDEO_R),
    .O_VIDEO_G     (O_VIDEO_G),
    .O_VIDEO_B     (O_VIDEO_B),
    .O_VBLANK      (O_VBLANK),
    .O_FRAME_START (O_FRAME_START)
  );

  always #5 CLK = ~CLK;

  int unsigned gcyc = 0;
  int unsigned base = 0;
  int          mode = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned hs_low = 0, vs_low = 0, fs_cnt = 0;
  exp_t        sb[$];

  always @(posedge CLK) gcyc <= gcyc + 1;

  // Framebuffer model with one CLK of read latency.
  always @(posedge CLK)
    vram.I_VRAM_DATA <= (mode == 0) ? 3'b101 : vram.O_VRAM_ADDR[2:0];

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "addr";
      K_RGB:   return "rgb";
      K_HS:    return "hsync";
      K_VS:    return "vsync";
      K_VB:    return "vblank";
      K_FS:    return "frame_start";
      K_HSLOW: return "hsync_low_cycles";
      K_VSLOW: return "vsync_low_cycles";
      default: return "frame_start_count";
    endcase
  endfunction

  function automatic int unsigned actual(input int k);
    case (k)
      K_ADDR:  return int'(vram.O_VRAM_ADDR);
      K_RGB:   return int'({O_VIDEO_R, O_VIDEO_G, O_VIDEO_B});
      K_HS:    return int'(O_HSYNC);
      K_VS:    return int'(O_VSYNC);
      K_VB:    return int'(O_VBLANK);
      K_FS:    return int'(O_FRAME_START);
      K_HSLOW: return hs_low;
      K_VSLOW: return vs_low;
      default: return fs_cnt;
    endcase
  endfunction

  task automatic expect_abs(input int unsigned at, input int k, input int unsigned v);
    exp_t e;
    int   i;
    e.at = at; e.kind = k; e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  // c = clock edges since reset release; pins show stage-0 position p at c = 2p+4, address at c = 2p+2.
  task automatic expect_at(input int unsigned c, input int k, input int unsigned v);
    expect_abs(base + c, k, v);
  endtask

  task automatic do_reset(input int n);
    I_RESET = 1'b1;
    expect_abs(gcyc + n, K_HS, 1);
    expect_abs(gcyc + n, K_VS, 1);
    expect_abs(gcyc + n, K_RGB, 0);
    expect_abs(gcyc + n, K_ADDR, 0);
    expect_abs(gcyc + n, K_VB, 1);
    expect_abs(gcyc + n, K_FS, 0);
    repeat (n) @(posedge CLK);
    #1;
    I_RESET = 1'b0;
    base = gcyc;
  endtask

  exp_t        m_e;
  int unsigned m_act;

  always @(negedge CLK) begin
    if (I_RESET) begin
      hs_low = 0; vs_low = 0; fs_cnt = 0;
    end else begin
      if (!O_HSYNC) hs_low++;
      if (!O_VSYNC) vs_low++;
      if (O_FRAME_START) fs_cnt++;
    end
    while (sb.size() > 0 && sb[0].at <= gcyc) begin
      m_e = sb.pop_front();
      m_act = actual(m_e.kind);
      checks++;
      if (m_e.at != gcyc || m_act != m_e.val) begin
        errors++;
        $display("FAIL %s at cycle %0d (now %0d): got %0h expected %0h",
                 kname(m_e.kind), m_e.at, gcyc, m_act, m_e.val);
      end
    end
  end

  initial begin
    do_reset(3);

    // Colour 3'b101 everywhere; address map, sync windows, blanking, frame start.
    expect_at(3, K_FS, 0);
    expect_at(4, K_FS, 1);
    expect_at(4, K_RGB, 12'hF0F);
    expect_at(5, K_FS, 0);
    expect_at(6, K_ADDR, 1);
    expect_at(14, K_RGB, 12'hF0F);
    expect_at(1282, K_ADDR, 0);
    expect_at(1284, K_RGB, 12'h000);
    expect_at(1314, K_HS, 1);
    expect_at(1316, K_HS, 0);
    expect_at(1506, K_HS, 0);
    expect_at(1508, K_HS, 1);
    expect_at(1604, K_HSLOW, 192);
    expect_at(1608, K_ADDR, 1);
    expect_at(3202, K_ADDR, 320);
    expect_at(11404, K_VB, 0);
    expect_at(11404, K_RGB, 12'hF0F);
    expect_at(12480, K_ADDR, 1279);
    expect_at(13004, K_VB, 1);
    expect_at(13004, K_RGB, 12'h000);
    expect_at(16002, K_VS, 1);
    expect_at(16004, K_VS, 0);
    expect_at(19202, K_VS, 0);
    expect_at(19204, K_VS, 1);
    expect_at(24002, K_FS, 0);
    expect_at(24004, K_FS, 1);
    expect_at(24004, K_VSLOW, 3200);
    expect_at(24006, K_FSCNT, 2);

    // Reset pulse while stage 0 sits at (400,5) of the second frame.
    while (gcyc < base + 32801) begin
      @(posedge CLK);
      #1;
    end
    mode = 1;
    do_reset(1);

    // Restart from (0,0); memory returns addr[2:0] so colours repeat per 2x2 block.
    expect_at(3, K_FS, 0);
    expect_at(4, K_FS, 1);
    expect_at(8, K_RGB, 12'h00F);
    expect_at(10, K_RGB, 12'h00F);
    expect_at(28, K_RGB, 12'hFF0);
    expect_at(32, K_RGB, 12'hFFF);
    expect_at(34, K_RGB, 12'hFFF);
    expect_at(1624, K_RGB, 12'hF0F);
    expect_at(3216, K_RGB, 12'h0FF);
    expect_at(4816, K_RGB, 12'h0FF);

    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(posedge CLK);
    @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never reached, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Video scan-out stage downstream of the CPU core's 320×240 3-bit framebuffer. Generates 640×480@60 VGA timing and reads one framebuffer word per displayed pixel. Each stored pixel is line- and pixel-doubled to 2×2 screen pixels. Each bit is expanded to 4-bit R/G/B, driving the board's O_HSYNC/O_VSYNC/O_VIDEO_* pins that the core currently ties low.

## Interface
Parameters:
- CLK_DIV, 2, CLK cycles per screen pixel (50 MHz CLK → 25 MHz pixel); legal ≥1
- H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in screen pixels (total 800)
- V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
- CLK  in  1  system clock; only clock
- I_RESET  in  1  reset, synchronous, active-high
- O_VRAM_ADDR  out  17  framebuffer read address, y*320+x
- I_VRAM_DATA  in  3  read data, valid 1 CLK after address; bit2=R, bit1=G, bit0=B
- O_HSYNC  out  1  horizontal sync, active-low
- O_VSYNC  out  1  vertical sync, active-low
- O_VIDEO_R / O_VIDEO_G / O_VIDEO_B  out  4 each  colour, 4'hF or 4'h0
- O_VBLANK  out  1  high while pin-side line is outside visible area
- O_FRAME_START  out  1  one-CLK pulse when pin-side position is (0,0)

## Operation
- div counter 0..CLK_DIV-1. Pixel tick = (div==CLK_DIV-1). All stages below advance only on tick.
- hcnt 0..799 wraps to 0 and increments vcnt. vcnt 0..524 wraps to 0.
- Stage 0 (counters): visible = hcnt<640 && vcnt<480. hsync_n = !(656≤hcnt≤751). vsync_n = !(490≤vcnt≤491).
- Stage 1 (address): O_VRAM_ADDR registered = (vcnt[8:1]<<8) + (vcnt[8:1]<<6) + hcnt[9:1] when visible, else 0. Max 76799, fits 17 bits, no overflow. visible/sync flags delayed alongside.
- Stage 2 (pins): sample I_VRAM_DATA. Each O_VIDEO_c = {4{bit}} if stage-1 visible, else 4'h0. Syncs and O_VBLANK from stage-1 flags.
- Sync and colour leave stage 2 together, so skew is 0.
- O_FRAME_START asserts for the single CLK on which stage 2 loads position (0,0).
- Read latency: the address is stable for CLK_DIV cycles before sampling. Any memory with ≤1-CLK synchronous latency works for CLK_DIV≥1.
- Reset values (all outputs, every stage register): O_HSYNC=1, O_VSYNC=1, RGB=0, O_VRAM_ADDR=0, O_VBLANK=1, O_FRAME_START=0. Counters reset to 0.
- Reset mid-frame: the next edge forces reset values regardless of position. Scan restarts at (0,0) and no partial line completes.
- Simultaneous hcnt and vcnt wrap at (799,524) both go to 0 on the same tick.

## Timing
- Pin latency: 2 pixel ticks from stage-0 position to pins.
- Line period: 800·CLK_DIV CLK. O_HSYNC low for 96·CLK_DIV CLK per line.
- Frame period: 420000·CLK_DIV CLK. O_VSYNC low for 1600·CLK_DIV CLK (2 full lines).
- O_VSYNC edges coincide with stage-2 hcnt=0 edges.
- Outputs are registered only; no combinational path from input to output.
- First tick is on the CLK_DIV-th edge after I_RESET deasserts.

## Structure
- Package vga_timing_pkg: H_/V_ timing constants, FB_WIDTH=320, FB_HEIGHT=240, FB_ADDR_W=17, pixel bit-position constants.
- Sub-module vga_sync_gen: div/hcnt/vcnt counters plus visible, hsync_n and vsync_n at stage 0.
- vga_scanout holds the address and pin pipeline.

## Test plan
- Reset: I_RESET high 3 CLK → HSYNC=1, VSYNC=1, RGB=0, ADDR=0, VBLANK=1, FRAME_START=0.
- Line/frame timing (CLK_DIV=2) → HSYNC period 1600 CLK, low 192 CLK. VSYNC period 840000 CLK, low 3200 CLK. FRAME_START exactly once per 840000 CLK.
- Address map:
  - stage-0 (hcnt,vcnt)=(2,0) and (3,1) → ADDR=1.
  - (0,2) → 320.
  - (639,479) → 76799.
  - (640,0) → 0.
- Colour: memory model returns 3'b101 everywhere → R=F, G=0, B=F on visible pins; all 0 while hcnt≥640 or vcnt≥480 at pins.
- Pattern: memory returns addr[2:0] → pin colour sequence repeats each value for 2 screen pixels, and each line pair is identical.
- Mid-line reset: pulse I_RESET at hcnt=400, vcnt=100 → reset values next CLK. Scan restarts at (0,0), and the first FRAME_START follows 2 ticks after the first tick.
